// File: rtl/train_sensor_frontend.sv
// Track-sensor front end: sync, debounce and prioritised rise-event issue for four sensors.
// Optional glitch counter output is enabled with SENSOR_GLITCH_CNT_EN.

module train_sensor_lane #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic lvl,
    output logic rise
`ifdef SENSOR_GLITCH_CNT_EN
    ,
    output logic glitch
`endif
);
    localparam logic [3:0] DB_LAST = 4'(DB_CYCLES - 1);

    logic       sync1, sync2;
    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            lvl   <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == lvl) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                lvl <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    // High on the edge where lvl is about to go 0->1.
    assign rise = sync2 & ~lvl & (cnt == DB_LAST);

`ifdef SENSOR_GLITCH_CNT_EN
    assign glitch = (sync2 == lvl) && (cnt != '0);
`endif

endmodule

module train_sensor_frontend #(
    parameter int DB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] raw_sens,
    input  logic       hold,
    input  logic       clr_ovr,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic [3:0] sens_lvl,
    output logic [3:0] pending,
    output logic       overrun
`ifdef SENSOR_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt
`endif
);
    localparam int NUM_LANES = 4;

    logic [NUM_LANES-1:0] rise;
    logic [NUM_LANES-1:0] issue;
    logic                 ovr_set;

`ifdef SENSOR_GLITCH_CNT_EN
    logic [NUM_LANES-1:0] glitch;
    logic [8:0]           g_sum;

    train_sensor_lane #(.DB_CYCLES(DB_CYCLES)) u_lane [NUM_LANES-1:0] (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw    (raw_sens),
        .lvl    (sens_lvl),
        .rise   (rise),
        .glitch (glitch)
    );

    always_comb begin
        g_sum = {1'b0, glitch_cnt};
        for (int i = 0; i < NUM_LANES; i++) g_sum = g_sum + 9'(glitch[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              glitch_cnt <= '0;
        else if (clr_ovr)        glitch_cnt <= '0;
        else if (g_sum > 9'd255) glitch_cnt <= 8'd255;
        else                     glitch_cnt <= g_sum[7:0];
    end
`else
    train_sensor_lane #(.DB_CYCLES(DB_CYCLES)) u_lane [NUM_LANES-1:0] (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (raw_sens),
        .lvl   (sens_lvl),
        .rise  (rise)
    );
`endif

    // Lowest set bit of pending is the highest-priority sensor (a = bit0).
    assign issue   = hold ? '0 : (pending & (~pending + 4'd1));
    assign ovr_set = |(rise & pending & ~issue);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending      <= '0;
            {d, c, b, a} <= '0;
            overrun      <= 1'b0;
        end else begin
            pending      <= (pending & ~issue) | rise;
            {d, c, b, a} <= issue;
            if (ovr_set)      overrun <= 1'b1;
            else if (clr_ovr) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_train_sensor_frontend.sv
// Directed bench for train_sensor_frontend; expected pulses are queued at stimulus time
// and matched by a monitor when a..d fire.

module tb_train_sensor_frontend;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] raw_sens;
    logic       hold, clr_ovr;
    logic       a, b, c, d;
    logic [3:0] sens_lvl, pending;
    logic       overrun;
`ifdef SENSOR_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif

    typedef struct {
        logic [3:0] vec;
        int         e;
    } exp_t;

    exp_t exp_q[$];
    int   edge_n = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    train_sensor_frontend #(.DB_CYCLES(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw_sens (raw_sens),
        .hold     (hold),
        .clr_ovr  (clr_ovr),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .sens_lvl (sens_lvl),
        .pending  (pending),
        .overrun  (overrun)
`ifdef SENSOR_GLITCH_CNT_EN
        ,
        .glitch_cnt (glitch_cnt)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_pulse(input logic [3:0] vec, input int e);
        exp_t x;
        x.vec = vec;
        x.e   = e;
        exp_q.push_back(x);
    endtask

    // Pulse monitor: one-hot check every cycle, scoreboard pop on any pulse.
    always @(posedge clk) begin
        exp_t x;
        #1;
        chk("onehot", 32'($onehot0({d, c, b, a})), 32'd1);
        if ({d, c, b, a} != 4'b0000) begin
            if (exp_q.size() != 0) begin
                x = exp_q.pop_front();
            end else begin
                x.vec = 4'b0000;
                x.e   = -1;
            end
            chk("pulse_vec", 32'({d, c, b, a}), 32'(x.vec));
            chk("pulse_edge", edge_n, x.e);
        end
    end

    initial begin
        int s;
        rst_n    = 1'b0;
        raw_sens = 4'b0000;
        hold     = 1'b0;
        clr_ovr  = 1'b0;

        // Reset state
        tick(2);
        chk("rst_lvl", 32'(sens_lvl), 32'h0);
        chk("rst_pend", 32'(pending), 32'h0);
        chk("rst_ovr", 32'(overrun), 32'h0);
        chk("rst_pulse", 32'({d, c, b, a}), 32'h0);
        tick(1);
        rst_n = 1'b1;

        // Sensor a: first sampled at edge 10, level after 15, pulse after 16
        while (edge_n < 9) tick(1);
        raw_sens = 4'b0001;
        push_pulse(4'b0001, 16);
        tick(5);
        chk("a_lvl_early", 32'(sens_lvl), 32'h0);
        tick(1);
        chk("a_lvl", 32'(sens_lvl), 32'h1);
        chk("a_pend", 32'(pending), 32'h1);
        tick(1);
        chk("a_pend_clr", 32'(pending), 32'h0);
        raw_sens = 4'b0000;
        tick(10);
        chk("a_fall_lvl", 32'(sens_lvl), 32'h0);

        // Sensor b glitch of 3 clocks
        raw_sens = 4'b0010;
        tick(3);
        raw_sens = 4'b0000;
        tick(10);
        chk("glitch_lvl", 32'(sens_lvl), 32'h0);
        chk("glitch_pend", 32'(pending), 32'h0);
`ifdef SENSOR_GLITCH_CNT_EN
        chk("glitch_cnt", 32'(glitch_cnt), 32'd1);
`endif

        // Simultaneous rise on a, c, d
        s = edge_n;
        raw_sens = 4'b1101;
        push_pulse(4'b0001, s + 7);
        push_pulse(4'b0100, s + 8);
        push_pulse(4'b1000, s + 9);
        tick(6);
        chk("multi_pend0", 32'(pending), 32'hd);
        tick(1);
        chk("multi_pend1", 32'(pending), 32'hc);
        tick(1);
        chk("multi_pend2", 32'(pending), 32'h8);
        tick(1);
        chk("multi_pend3", 32'(pending), 32'h0);
        raw_sens = 4'b0000;
        tick(10);

        // Overrun: b rises, falls, rises under hold
        hold = 1'b1;
        raw_sens = 4'b0010;
        tick(8);
        chk("hold_pend", 32'(pending), 32'h2);
        raw_sens = 4'b0000;
        tick(8);
        chk("hold_no_ovr", 32'(overrun), 32'h0);
        raw_sens = 4'b0010;
        tick(8);
        chk("ovr_set", 32'(overrun), 32'h1);
        chk("ovr_pend", 32'(pending), 32'h2);
        s = edge_n;
        push_pulse(4'b0010, s + 1);
        hold = 1'b0;
        tick(1);
        chk("ovr_issue_pend", 32'(pending), 32'h0);
        chk("ovr_sticky", 32'(overrun), 32'h1);
        tick(2);
        clr_ovr = 1'b1;
        tick(1);
        clr_ovr = 1'b0;
        chk("ovr_clr", 32'(overrun), 32'h0);
`ifdef SENSOR_GLITCH_CNT_EN
        chk("glitch_clr", 32'(glitch_cnt), 32'd0);
`endif
        raw_sens = 4'b0000;
        tick(10);

        // Reset mid-cycle with events pending under hold
        hold = 1'b1;
        raw_sens = 4'b0110;
        tick(8);
        chk("rst_pre_pend", 32'(pending), 32'h6);
        raw_sens = 4'b0000;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_pend", 32'(pending), 32'h0);
        chk("midrst_lvl", 32'(sens_lvl), 32'h0);
        chk("midrst_ovr", 32'(overrun), 32'h0);
        chk("midrst_pulse", 32'({d, c, b, a}), 32'h0);
        tick(2);
        rst_n = 1'b1;
        hold  = 1'b0;
        tick(20);
        chk("post_rst_pend", 32'(pending), 32'h0);
        chk("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
